// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FLUSH    = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b01
    } fwd_sel_e;

    localparam logic [31:0] c_nop_instr = 32'h00000013;

    // Per-cycle pipeline-register control bundle
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } ctrl_t;

    localparam ctrl_t c_ctrl_run    = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                        exmem_en: 1'b1, memwb_en: 1'b1,
                                        ifid_flush: 1'b0, idex_flush: 1'b0};
    localparam ctrl_t c_ctrl_freeze = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0,
                                        exmem_en: 1'b0, memwb_en: 1'b0,
                                        ifid_flush: 1'b0, idex_flush: 1'b0};
    localparam ctrl_t c_ctrl_flush  = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                        exmem_en: 1'b1, memwb_en: 1'b1,
                                        ifid_flush: 1'b1, idex_flush: 1'b1};
    localparam ctrl_t c_ctrl_reset  = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0,
                                        exmem_en: 1'b0, memwb_en: 1'b0,
                                        ifid_flush: 1'b1, idex_flush: 1'b1};

    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_unit
// Description : Combinational EX-stage forwarding select for one operand.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output fwd_sel_e   fwd_sel
);

    // The younger producer in MEM shadows an older one in WB
    always_comb begin
        fwd_sel = FWD_RF;
        if (mem_reg_write && reg_match(mem_rd, ex_rs)) begin
            fwd_sel = FWD_MEM;
        end else if (wb_reg_write && reg_match(wb_rd, ex_rs)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush/forwarding controller for the 5-stage RV pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ext_stall_i,
    input  logic             ext_flush_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic [4:0]       ex_rs1_i,
    input  logic [4:0]       ex_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_branch_taken_i,
    input  logic [4:0]       mem_rd_i,
    input  logic             mem_reg_write_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    input  logic [4:0]       wb_rd_i,
    input  logic             wb_reg_write_i,
    output logic             pc_en_o,
    output logic             ifid_en_o,
    output logic             idex_en_o,
    output logic             exmem_en_o,
    output logic             memwb_en_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // Statistics never need to be wider than the datapath
    localparam int         c_cnt_w        = (CNT_W < XLEN) ? CNT_W : XLEN;
    localparam logic [3:0] c_flush_reload = 4'(FLUSH_CYCLES - 1);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [3:0]           r_flush_left;
    logic [3:0]           w_flush_left_nxt;
    logic [c_cnt_w-1:0]   r_stall_cnt;
    logic [c_cnt_w-1:0]   r_flush_cnt;
    ctrl_t                w_ctrl;
    ctrl_t                w_ctrl_out;
    fwd_sel_e             w_fwd_a;
    fwd_sel_e             w_fwd_b;
    logic                 w_dmem_stall;
    logic                 w_load_use;

    fwd_unit u_fwd_a (
        .ex_rs         (ex_rs1_i),
        .mem_rd        (mem_rd_i),
        .mem_reg_write (mem_reg_write_i),
        .wb_rd         (wb_rd_i),
        .wb_reg_write  (wb_reg_write_i),
        .fwd_sel       (w_fwd_a)
    );

    fwd_unit u_fwd_b (
        .ex_rs         (ex_rs2_i),
        .mem_rd        (mem_rd_i),
        .mem_reg_write (mem_reg_write_i),
        .wb_rd         (wb_rd_i),
        .wb_reg_write  (wb_reg_write_i),
        .fwd_sel       (w_fwd_b)
    );

    assign w_dmem_stall = dmem_req_i && !dmem_ready_i;
    assign w_load_use   = ex_mem_read_i &&
                          (reg_match(ex_rd_i, id_rs1_i) || reg_match(ex_rd_i, id_rs2_i));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= RUN;
            r_flush_left <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_left <= w_flush_left_nxt;
        end
    end

    always_comb begin
        w_ctrl           = c_ctrl_run;
        w_state_nxt      = r_state;
        w_flush_left_nxt = r_flush_left;
        case (r_state)
            RUN: begin
                if (w_dmem_stall) begin
                    w_ctrl      = c_ctrl_freeze;
                    w_state_nxt = MEM_WAIT;
                end else if (ex_branch_taken_i) begin
                    w_ctrl = c_ctrl_flush;
                end else if (ext_flush_i) begin
                    w_ctrl           = c_ctrl_flush;
                    w_flush_left_nxt = c_flush_reload;
                    if (c_flush_reload != 4'd0) begin
                        w_state_nxt = FLUSH;
                    end
                end else if (w_load_use) begin
                    w_ctrl.pc_en      = 1'b0;
                    w_ctrl.ifid_en    = 1'b0;
                    w_ctrl.idex_flush = 1'b1;
                end else if (ext_stall_i) begin
                    w_ctrl = c_ctrl_freeze;
                end
            end
            MEM_WAIT: begin
                // A non-zero remaining count means a flush was interrupted
                if (dmem_ready_i) begin
                    w_state_nxt = (r_flush_left != 4'd0) ? FLUSH : RUN;
                end else begin
                    w_ctrl = c_ctrl_freeze;
                end
            end
            FLUSH: begin
                if (w_dmem_stall) begin
                    w_ctrl      = c_ctrl_freeze;
                    w_state_nxt = MEM_WAIT;
                end else begin
                    w_ctrl = c_ctrl_flush;
                    if (ext_flush_i) begin
                        w_flush_left_nxt = c_flush_reload;
                    end else begin
                        w_flush_left_nxt = r_flush_left - 4'd1;
                    end
                    if (w_flush_left_nxt == 4'd0) begin
                        w_state_nxt = RUN;
                    end
                end
            end
            default: begin
                w_state_nxt      = RUN;
                w_flush_left_nxt = 4'd0;
            end
        endcase
    end

    // Reset acts on the outputs immediately, not at the next edge
    assign w_ctrl_out = reset ? c_ctrl_reset : w_ctrl;

    assign pc_en_o      = w_ctrl_out.pc_en;
    assign ifid_en_o    = w_ctrl_out.ifid_en;
    assign idex_en_o    = w_ctrl_out.idex_en;
    assign exmem_en_o   = w_ctrl_out.exmem_en;
    assign memwb_en_o   = w_ctrl_out.memwb_en;
    assign ifid_flush_o = w_ctrl_out.ifid_flush;
    assign idex_flush_o = w_ctrl_out.idex_flush;
    assign fwd_a_o      = reset ? FWD_RF : w_fwd_a;
    assign fwd_b_o      = reset ? FWD_RF : w_fwd_b;
    assign state_o      = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_ctrl.pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_w'(1);
            end
            if (w_ctrl.ifid_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + c_cnt_w'(1);
            end
        end
    end

    assign stall_cnt_o = CNT_W'(r_stall_cnt);
    assign flush_cnt_o = CNT_W'(r_flush_cnt);

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed self-checking bench for pipeline_hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ext_stall_i = 1'b0, ext_flush_i = 1'b0;
    logic [4:0]  id_rs1_i = '0, id_rs2_i = '0, ex_rs1_i = '0, ex_rs2_i = '0, ex_rd_i = '0;
    logic        ex_mem_read_i = 1'b0, ex_branch_taken_i = 1'b0;
    logic [4:0]  mem_rd_i = '0, wb_rd_i = '0;
    logic        mem_reg_write_i = 1'b0, wb_reg_write_i = 1'b0;
    logic        dmem_req_i = 1'b0, dmem_ready_i = 1'b0;
    logic        pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o;
    logic        ifid_flush_o, idex_flush_o;
    logic [1:0]  fwd_a_o, fwd_b_o, state_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_hazard_ctrl #(.XLEN(64), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .ext_stall_i(ext_stall_i), .ext_flush_i(ext_flush_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i), .ex_rd_i(ex_rd_i),
        .ex_mem_read_i(ex_mem_read_i), .ex_branch_taken_i(ex_branch_taken_i),
        .mem_rd_i(mem_rd_i), .mem_reg_write_i(mem_reg_write_i),
        .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
        .wb_rd_i(wb_rd_i), .wb_reg_write_i(wb_reg_write_i),
        .pc_en_o(pc_en_o), .ifid_en_o(ifid_en_o), .idex_en_o(idex_en_o),
        .exmem_en_o(exmem_en_o), .memwb_en_o(memwb_en_o),
        .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .state_o(state_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_state", state_o, 2'b00);
        chk("rst_stall_cnt", stall_cnt_o, 0);
        chk("rst_flush_cnt", flush_cnt_o, 0);
        chk("rst_enables", {pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o}, 5'b00000);
        chk("rst_flushes", {ifid_flush_o, idex_flush_o}, 2'b11);
        chk("rst_fwd", {fwd_a_o, fwd_b_o}, 4'b0000);
        tick();
        reset = 1'b0;
        #1;
        chk("idle_enables", {pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o}, 5'b11111);
        chk("idle_flushes", {ifid_flush_o, idex_flush_o}, 2'b00);

        // Forwarding
        mem_rd_i = 5'd5; mem_reg_write_i = 1'b1; wb_rd_i = 5'd5; wb_reg_write_i = 1'b1;
        ex_rs1_i = 5'd5; #1;
        chk("fwd_a_mem", fwd_a_o, 2'b10);
        mem_rd_i = 5'd0; #1;
        chk("fwd_a_wb", fwd_a_o, 2'b01);
        mem_rd_i = 5'd5; mem_reg_write_i = 1'b0; #1;
        chk("fwd_a_wb_nowrite", fwd_a_o, 2'b01);
        ex_rs2_i = 5'd0; wb_rd_i = 5'd0; #1;
        chk("fwd_b_x0", fwd_b_o, 2'b00);
        chk("fwd_a_none", fwd_a_o, 2'b00);
        mem_reg_write_i = 1'b1; ex_rs2_i = 5'd5; #1;
        chk("fwd_b_mem", fwd_b_o, 2'b10);
        mem_rd_i = '0; mem_reg_write_i = 1'b0; wb_reg_write_i = 1'b0; ex_rs1_i = '0; ex_rs2_i = '0;

        // Load-use
        ex_mem_read_i = 1'b1; ex_rd_i = 5'd8; id_rs2_i = 5'd8; #1;
        chk("lu_ctrl", {pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o,
                        ifid_flush_o, idex_flush_o}, 7'b0011101);
        chk("lu_state", state_o, 2'b00);
        tick();
        ex_mem_read_i = 1'b0; ex_rd_i = '0; id_rs2_i = '0; #1;
        chk("lu_stall_cnt", stall_cnt_o, 1);
        chk("lu_released", {pc_en_o, idex_flush_o}, 2'b10);

        // Memory wait: 3 cycles not ready, then ready
        dmem_req_i = 1'b1; dmem_ready_i = 1'b0; #1;
        chk("mw0_enables", {pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o}, 5'b00000);
        chk("mw0_state", state_o, 2'b00);
        tick();
        chk("mw1_state", state_o, 2'b01);
        chk("mw1_enables", {pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o}, 5'b00000);
        tick();
        chk("mw2_state", state_o, 2'b01);
        chk("mw2_exmem_en", exmem_en_o, 1'b0);
        tick();
        dmem_ready_i = 1'b1; #1;
        chk("mw_ready_state", state_o, 2'b01);
        chk("mw_ready_ctrl", {pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o,
                              ifid_flush_o, idex_flush_o}, 7'b1111100);
        tick();
        dmem_req_i = 1'b0; dmem_ready_i = 1'b0; #1;
        chk("mw_done_state", state_o, 2'b00);
        chk("mw_stall_cnt", stall_cnt_o, 4);

        // External flush, FLUSH_CYCLES = 2
        ext_flush_i = 1'b1; #1;
        chk("fl0_ctrl", {pc_en_o, ifid_flush_o, idex_flush_o}, 3'b111);
        tick();
        ext_flush_i = 1'b0; #1;
        chk("fl1_state", state_o, 2'b10);
        chk("fl1_ctrl", {pc_en_o, ifid_flush_o, idex_flush_o}, 3'b111);
        tick();
        chk("fl2_state", state_o, 2'b00);
        chk("fl2_flushes", {ifid_flush_o, idex_flush_o}, 2'b00);
        chk("fl_flush_cnt", flush_cnt_o, 2);

        // Taken branch beats load-use
        ex_branch_taken_i = 1'b1; ex_mem_read_i = 1'b1; ex_rd_i = 5'd3; id_rs1_i = 5'd3; #1;
        chk("br_lu_ctrl", {pc_en_o, ifid_en_o, idex_en_o, ifid_flush_o, idex_flush_o}, 5'b11111);
        tick();
        ex_branch_taken_i = 1'b0; ex_mem_read_i = 1'b0; ex_rd_i = '0; id_rs1_i = '0; #1;
        chk("br_flush_cnt", flush_cnt_o, 3);
        chk("br_stall_cnt", stall_cnt_o, 4);
        chk("br_state", state_o, 2'b00);

        // dmem stall beats external flush
        dmem_req_i = 1'b1; ext_flush_i = 1'b1; #1;
        chk("mw_fl_ctrl", {pc_en_o, ifid_flush_o, idex_flush_o}, 3'b000);
        tick();
        ext_flush_i = 1'b0; #1;
        chk("mw_fl_state", state_o, 2'b01);
        chk("mw_fl_flush_cnt", flush_cnt_o, 3);

        // Asynchronous reset while in MEM_WAIT
        reset = 1'b1; #1;
        chk("arst_state", state_o, 2'b00);
        chk("arst_cnts", {stall_cnt_o, flush_cnt_o}, 64'd0);
        chk("arst_flushes", {ifid_flush_o, idex_flush_o}, 2'b11);
        tick();
        reset = 1'b0; dmem_req_i = 1'b0; #1;

        // Flush interrupted by a dmem stall resumes afterwards
        ext_flush_i = 1'b1; #1;
        tick();
        ext_flush_i = 1'b0; dmem_req_i = 1'b1; dmem_ready_i = 1'b0; #1;
        chk("rs_flush_state", state_o, 2'b10);
        chk("rs_stall_ctrl", {pc_en_o, ifid_flush_o}, 2'b00);
        tick();
        dmem_ready_i = 1'b1; #1;
        chk("rs_wait_state", state_o, 2'b01);
        tick();
        dmem_req_i = 1'b0; dmem_ready_i = 1'b0; #1;
        chk("rs_resume_state", state_o, 2'b10);
        chk("rs_resume_flush", {pc_en_o, ifid_flush_o, idex_flush_o}, 3'b111);
        tick();
        chk("rs_end_state", state_o, 2'b00);
        chk("rs_cnts", {stall_cnt_o, flush_cnt_o}, {32'd1, 32'd2});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
